// File: rtl/otter_alu_pkg.sv
// Shared ALU opcodes and the multiply-sequencer state set.
package otter_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_COPY = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHL,
    ST_SHR,
    ST_FINISH
  } mul_state_e;

  // Multiplier exhausted -> done; low bit set -> accumulate; else just shift.
  function automatic mul_state_e next_iter(input logic [31:0] m);
    if (m == 32'd0)  return ST_FINISH;
    else if (m[0])   return ST_ADD;
    else             return ST_SHL;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the shared external ALU for every add and shift.
// state  | meaning
// IDLE   | waiting for START, ALU released (COPY, zero operands)
// ADD    | ACC <= ACC + MCAND
// SHL    | MCAND <= MCAND << 1
// SHR    | MPLIER <= MPLIER >> 1, early exit once it reaches zero
// FINISH | DONE pulse, PRODUCT valid
module alu_mul_seq
  import otter_alu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  output logic [31:0] ALU_SRC_A,
  output logic [31:0] ALU_SRC_B,
  output logic [3:0]  ALU_FUN,
  input  logic [31:0] ALU_RESULT,
  output logic        ALU_SEL,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] PRODUCT
);

  mul_state_e  state_q, state_d;
  logic [31:0] acc_q, mcand_q, mplier_q, product_q;
  logic        busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    ALU_FUN   = ALU_COPY;
    ALU_SRC_A = 32'd0;
    ALU_SRC_B = 32'd0;
    case (state_q)
      ST_IDLE:   if (START) state_d = next_iter(OP_B);
      ST_ADD: begin
        ALU_FUN   = ALU_ADD;
        ALU_SRC_A = acc_q;
        ALU_SRC_B = mcand_q;
        state_d   = ST_SHL;
      end
      ST_SHL: begin
        ALU_FUN   = ALU_SLL;
        ALU_SRC_A = mcand_q;
        ALU_SRC_B = 32'd1;
        state_d   = ST_SHR;
      end
      ST_SHR: begin
        ALU_FUN   = ALU_SRL;
        ALU_SRC_A = mplier_q;
        ALU_SRC_B = 32'd1;
        state_d   = next_iter(ALU_RESULT);
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      acc_q     <= 32'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      product_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (START) begin
          acc_q    <= 32'd0;
          mcand_q  <= OP_A;
          mplier_q <= OP_B;
        end
        ST_ADD:  acc_q    <= ALU_RESULT;
        ST_SHL:  mcand_q  <= ALU_RESULT;
        ST_SHR:  mplier_q <= ALU_RESULT;
        default: ;
      endcase
      // Load PRODUCT on entry to FINISH so it is already valid while DONE is high.
      if (state_d == ST_FINISH)
        product_q <= (state_q == ST_IDLE) ? 32'd0 : acc_q;
      done_q <= (state_d == ST_FINISH);
      busy_q <= (state_d == ST_ADD) || (state_d == ST_SHL) || (state_d == ST_SHR);
    end
  end

  assign BUSY    = busy_q;
  assign ALU_SEL = busy_q;
  assign DONE    = done_q;
  assign PRODUCT = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq driving a behavioural copy of the shared ALU.
module tb_alu_mul_seq;

  logic        CLK, RST, START;
  logic [31:0] OP_A, OP_B;
  logic [31:0] ALU_SRC_A, ALU_SRC_B, ALU_RESULT, PRODUCT;
  logic [3:0]  ALU_FUN;
  logic        ALU_SEL, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  alu_mul_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .OP_A(OP_A), .OP_B(OP_B),
    .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_FUN(ALU_FUN),
    .ALU_RESULT(ALU_RESULT), .ALU_SEL(ALU_SEL), .BUSY(BUSY), .DONE(DONE),
    .PRODUCT(PRODUCT)
  );

  // Shared combinational ALU
  always_comb begin
    case (ALU_FUN)
      4'b0000: ALU_RESULT = ALU_SRC_A + ALU_SRC_B;
      4'b0001: ALU_RESULT = ALU_SRC_A << ALU_SRC_B[4:0];
      4'b0101: ALU_RESULT = ALU_SRC_A >> ALU_SRC_B[4:0];
      4'b1001: ALU_RESULT = ALU_SRC_A;
      default: ALU_RESULT = 32'd0;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one START, then watches up to 110 cycles (cycle k = after k edges).
  // rs_cyc/rst_cyc > 0 inject a second START or a reset after that cycle.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input int rs_cyc, input logic [31:0] ra, input logic [31:0] rb,
                         input int rst_cyc,
                         output int lat, output int busy_n, output int first_add,
                         output int done_n, output int sel_bad);
    int extra;
    lat = -1; busy_n = 0; first_add = -1; done_n = 0; sel_bad = 0; extra = 0;
    @(negedge CLK);
    START = 1'b1; OP_A = a; OP_B = b;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(negedge CLK);
      START = 1'b0; RST = 1'b0; OP_A = ~a; OP_B = ~b;
      if (DONE) begin
        done_n++;
        if (lat < 0) lat = cyc;
      end
      if (BUSY) busy_n++;
      if (ALU_SEL !== BUSY) sel_bad++;
      if (BUSY && ALU_FUN == 4'b0000 && first_add < 0) first_add = cyc;
      if (cyc == rs_cyc) begin START = 1'b1; OP_A = ra; OP_B = rb; end
      if (cyc == rst_cyc) RST = 1'b1;
      if (lat >= 0) begin
        extra++;
        if (extra > 3) break;
      end
    end
  endtask

  int lat, busy_n, first_add, done_n, sel_bad;

  initial begin
    RST = 1'b1; START = 1'b0; OP_A = 32'd0; OP_B = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_sel", {31'd0, ALU_SEL}, 32'd0);
    check("rst_fun", {28'd0, ALU_FUN}, 32'h9);
    check("rst_src_a", ALU_SRC_A, 32'd0);
    check("rst_src_b", ALU_SRC_B, 32'd0);
    check("rst_product", PRODUCT, 32'd0);
    RST = 1'b0;

    // 6*7: p=3, n1=3 -> L=10
    run_mul(32'd6, 32'd7, 0, 0, 0, 0, lat, busy_n, first_add, done_n, sel_bad);
    check("s1_product", PRODUCT, 32'd42);
    check("s1_latency", lat, 32'd10);
    check("s1_busy_cycles", busy_n, 32'd9);
    check("s1_done_count", done_n, 32'd1);
    check("s1_sel_eq_busy", sel_bad, 32'd0);
    repeat (5) @(negedge CLK);
    check("s1_product_hold", PRODUCT, 32'd42);

    // Zero multiplier: immediate FINISH
    run_mul(32'h12345678, 32'd0, 0, 0, 0, 0, lat, busy_n, first_add, done_n, sel_bad);
    check("s2_product", PRODUCT, 32'd0);
    check("s2_latency", lat, 32'd1);
    check("s2_busy_cycles", busy_n, 32'd0);

    // All ones: p=32, n1=32 -> L=97
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, lat, busy_n, first_add, done_n, sel_bad);
    check("s3_product", PRODUCT, 32'h00000001);
    check("s3_latency", lat, 32'd97);
    check("s3_busy_cycles", busy_n, 32'd96);

    // Single top bit: 31 shift-only iterations, then ADD at cycle 63
    run_mul(32'd3, 32'h80000000, 0, 0, 0, 0, lat, busy_n, first_add, done_n, sel_bad);
    check("s4_product", PRODUCT, 32'h80000000);
    check("s4_latency", lat, 32'd66);
    check("s4_first_add", first_add, 32'd63);

    // Second START mid-operation is ignored; 5*5: p=3, n1=2 -> L=9
    run_mul(32'd5, 32'd5, 2, 32'd9, 32'd9, 0, lat, busy_n, first_add, done_n, sel_bad);
    check("s5_product", PRODUCT, 32'd25);
    check("s5_latency", lat, 32'd9);
    check("s5_done_count", done_n, 32'd1);
    repeat (3) @(negedge CLK);
    check("s5_idle_busy", {31'd0, BUSY}, 32'd0);

    // Reset mid-operation aborts with no DONE
    run_mul(32'd100, 32'd100, 0, 0, 0, 4, lat, busy_n, first_add, done_n, sel_bad);
    check("s6_done_count", done_n, 32'd0);
    check("s6_busy", {31'd0, BUSY}, 32'd0);
    check("s6_product", PRODUCT, 32'd0);
    check("s6_fun", {28'd0, ALU_FUN}, 32'h9);

    // Fresh start after abort: 2*3, p=2, n1=2 -> L=7
    run_mul(32'd2, 32'd3, 0, 0, 0, 0, lat, busy_n, first_add, done_n, sel_bad);
    check("s7_product", PRODUCT, 32'd6);
    check("s7_latency", lat, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
